// File: rtl/seq_mult_ctrl.sv
// Iterative 16x16 unsigned multiplier: one adder row reused for
// sixteen cycles, with a start/done handshake around it.
module seq_mult_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [IDX_W-1:0]   idx;
  logic               qj;
  logic [WIDTH-1:0]   row_in;
  logic [WIDTH-1:0]   row_sum;
  logic               row_cy;
  logic               last;

  assign idx  = cnt_q[IDX_W-1:0];
  assign qj   = q_q[idx];
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // Cell i sees the previous row's sum shifted down one place;
  // the top cell takes the previous row's carry-out instead.
  assign row_in = {c_q, p_q[WIDTH-1:1]};

  always_comb begin
    logic ai;
    logic cy;
    row_sum = '0;
    cy      = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      ai         = m_q[i] & qj;
      row_sum[i] = ai ^ row_in[i] ^ cy;
      cy         = (ai & row_in[i]) | (ai & cy) | (row_in[i] & cy);
    end
    row_cy = cy;
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    p_d     = p_q;
    c_d     = c_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          p_d     = '0;
          c_d     = 1'b0;
          lo_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        p_d      = row_sum;
        c_d      = row_cy;
        lo_d[idx] = row_sum[0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          prod_d  = {row_cy, row_sum, lo_q[WIDTH-2:0]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      c_q     <= 1'b0;
      lo_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      p_q     <= p_d;
      c_q     <= c_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: stimulus pushes expected
// products, a monitor pops them on each done pulse.
module tb_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  seq_mult_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    int          sc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      check("done_width", {31'd0, done_prev}, 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done: got product %h, expected none",
                 product);
      end else begin
        e = sb.pop_front();
        check("product", product, e.p);
        check("latency", cyc - e.sc, 32'd16);
      end
    end
    done_prev = done;
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1, expected 0");
    end
  endtask

  // Returns on the falling edge right after the accepting edge.
  task automatic run_vec(input logic [15:0] aa, input logic [15:0] bb,
                         input logic [31:0] ex);
    exp_t e;
    @(negedge clk);
    wait_idle();
    a     = aa;
    b     = bb;
    start = 1'b1;
    e.p   = ex;
    e.sc  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[6] = '{
    '{16'h0003, 16'h0005, 32'h0000000F},
    '{16'hFFFF, 16'hFFFF, 32'hFFFE0001},
    '{16'h8000, 16'h0002, 32'h00010000},
    '{16'h1234, 16'h0000, 32'h00000000},
    '{16'h0000, 16'hFFFF, 32'h00000000},
    '{16'h0100, 16'h0100, 32'h00010000}
  };

  initial begin
    int   n;
    exp_t e;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", product, 32'd0);

    // rst and start together: reset wins
    start = 1'b1;
    a     = 16'h00FF;
    b     = 16'h00FF;
    @(negedge clk);
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    // test 1 with busy-length measurement
    run_vec(16'd3, 16'd5, 32'h0000000F);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 32'd17);

    for (int i = 1; i < 6; i++)
      run_vec(vecs[i].a, vecs[i].b, vecs[i].p);

    // start pulses mid-run with new operands are ignored
    run_vec(16'h00AB, 16'h0102, 32'h0000AC56);
    repeat (4) @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("product_hold", product, 32'h00010000);

    // reset mid-run discards the result
    run_vec(16'h4321, 16'h1234, 32'h04C5F4B4);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    e = sb.pop_back();
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_product", product, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_done", product, 32'd0);
    run_vec(16'h4321, 16'h1234, 32'h04C5F4B4);

    // back-to-back: start held high, accepted every 18 cycles
    @(negedge clk);
    wait_idle();
    for (int k = 0; k < 6; k++) begin
      a     = vecs[k].a;
      b     = vecs[k].b;
      start = 1'b1;
      e.p   = vecs[k].p;
      e.sc  = cyc + 1;
      sb.push_back(e);
      if (k < 5) repeat (18) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_vec(ra, rb, 32'(ra) * 32'(rb));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
